// File: rtl/pc_pipeline_unit.sv
// Fetch PC and FD/XB pipeline-valid state for the two-stage core.
// Picks the next fetch address and feeds PC/bubble state to the CSR unit.
module pc_pipeline_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        FD_branch_taken,
  input  logic [31:0] FD_branch_target,
  input  logic        FD_mret,
  input  logic        initiate_exception,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic [31:0] i_addr,
  output logic [31:0] FD_pc,
  output logic        FD_bubble,
  output logic [31:0] XB_pc,
  output logic        XB_bubble,
  output logic [31:0] nextPC,
  output logic        XB_FD_exception_instruction_misaligned
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] xb_pc_q, xb_pc_d;
  logic        fd_bubble_q, fd_bubble_d;
  logic        xb_bubble_q, xb_bubble_d;
  logic        mis_q, mis_d;

  logic fd_valid;
  logic br_taken;
  logic mis;
  logic mret;

  assign fd_valid = ~fd_bubble_q;
  assign br_taken = fd_valid & FD_branch_taken;
  assign mis      = br_taken & (|FD_branch_target[1:0]);
  assign mret     = fd_valid & FD_mret;

  assign nextPC = br_taken ? FD_branch_target : fd_pc_q + 32'd4;

  // Trap outranks stall: stall is ignored in a trap cycle.
  always_comb begin
    pc_d        = pc_q;
    fd_pc_d     = fd_pc_q;
    xb_pc_d     = xb_pc_q;
    fd_bubble_d = fd_bubble_q;
    xb_bubble_d = xb_bubble_q;
    mis_d       = mis_q;
    priority case (1'b1)
      initiate_exception: begin
        pc_d        = csr_mtvec;
        fd_pc_d     = pc_q;
        xb_pc_d     = fd_pc_q;
        fd_bubble_d = 1'b1;
        xb_bubble_d = 1'b1;
        mis_d       = 1'b0;
      end
      stall: begin
      end
      mret: begin
        pc_d        = csr_mepc;
        fd_pc_d     = pc_q;
        xb_pc_d     = fd_pc_q;
        fd_bubble_d = 1'b1;
        xb_bubble_d = fd_bubble_q;
        mis_d       = mis;
      end
      (br_taken & ~mis): begin
        pc_d        = FD_branch_target;
        fd_pc_d     = pc_q;
        xb_pc_d     = fd_pc_q;
        fd_bubble_d = 1'b1;
        xb_bubble_d = fd_bubble_q;
        mis_d       = mis;
      end
      default: begin
        pc_d        = pc_q + 32'd4;
        fd_pc_d     = pc_q;
        xb_pc_d     = fd_pc_q;
        fd_bubble_d = 1'b0;
        xb_bubble_d = fd_bubble_q;
        mis_d       = mis;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      fd_pc_q     <= 32'd0;
      xb_pc_q     <= 32'd0;
      fd_bubble_q <= 1'b1;
      xb_bubble_q <= 1'b1;
      mis_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      fd_pc_q     <= fd_pc_d;
      xb_pc_q     <= xb_pc_d;
      fd_bubble_q <= fd_bubble_d;
      xb_bubble_q <= xb_bubble_d;
      mis_q       <= mis_d;
    end
  end

  assign i_addr    = pc_q;
  assign FD_pc     = fd_pc_q;
  assign FD_bubble = fd_bubble_q;
  assign XB_pc     = xb_pc_q;
  assign XB_bubble = xb_bubble_q;
  assign XB_FD_exception_instruction_misaligned = mis_q;

endmodule

// File: tb/tb_pc_pipeline_unit.sv
// Scoreboard bench for pc_pipeline_unit.
// Expectations queue up with stimulus and are popped after each edge.
module tb_pc_pipeline_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        FD_branch_taken;
  logic [31:0] FD_branch_target;
  logic        FD_mret;
  logic        initiate_exception;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] i_addr;
  logic [31:0] FD_pc;
  logic        FD_bubble;
  logic [31:0] XB_pc;
  logic        XB_bubble;
  logic [31:0] nextPC;
  logic        mis_flag;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] sb [$];
  logic [31:0] e;

  pc_pipeline_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .FD_branch_taken(FD_branch_taken),
    .FD_branch_target(FD_branch_target),
    .FD_mret(FD_mret),
    .initiate_exception(initiate_exception),
    .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .i_addr(i_addr),
    .FD_pc(FD_pc),
    .FD_bubble(FD_bubble),
    .XB_pc(XB_pc),
    .XB_bubble(XB_bubble),
    .nextPC(nextPC),
    .XB_FD_exception_instruction_misaligned(mis_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(output logic [31:0] v);
    if (sb.size() == 0) begin
      v = 32'hDEAD_BEEF;
      n_fail++;
      $display("FAIL scoreboard_empty: got empty queue want entry");
    end else begin
      v = sb.pop_front();
    end
  endtask

  task automatic idle();
    stall = 0; FD_branch_taken = 0; FD_branch_target = 0;
    FD_mret = 0; initiate_exception = 0;
    csr_mtvec = 0; csr_mepc = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    repeat (3) tick();
    reset = 0;
  endtask

  // Leaves FD_pc = 0x08 valid, i_addr = 0x0C.
  task automatic go_to_fd8();
    do_reset();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h1);
    sb.push_back(32'h1);
    sb.push_back(32'h0);
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL rst_iaddr: got %h want %h", i_addr, e); end
    pop(e); n_chk++;
    if (FD_pc !== e) begin n_fail++; $display("FAIL rst_fdpc: got %h want %h", FD_pc, e); end
    pop(e); n_chk++;
    if (XB_pc !== e) begin n_fail++; $display("FAIL rst_xbpc: got %h want %h", XB_pc, e); end
    pop(e); n_chk++;
    if (FD_bubble !== e[0]) begin n_fail++; $display("FAIL rst_fdb: got %b want %b", FD_bubble, e[0]); end
    pop(e); n_chk++;
    if (XB_bubble !== e[0]) begin n_fail++; $display("FAIL rst_xbb: got %b want %b", XB_bubble, e[0]); end
    pop(e); n_chk++;
    if (mis_flag !== e[0]) begin n_fail++; $display("FAIL rst_flag: got %b want %b", mis_flag, e[0]); end
    sb.push_back(32'h4);
    sb.push_back(32'h0);
    sb.push_back(32'h8);
    sb.push_back(32'h0);
    tick();
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL seq_iaddr1: got %h want %h", i_addr, e); end
    pop(e); n_chk++;
    if ({FD_pc[30:0], FD_bubble} !== {e[30:0], 1'b0}) begin
      n_fail++; $display("FAIL seq_fd1: got pc %h b %b want pc %h b 0", FD_pc, FD_bubble, e);
    end
    tick();
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL seq_iaddr2: got %h want %h", i_addr, e); end
    pop(e); n_chk++;
    if (XB_pc !== e || XB_bubble !== 1'b0) begin
      n_fail++; $display("FAIL seq_xb2: got pc %h b %b want pc %h b 0", XB_pc, XB_bubble, e);
    end
  endtask

  task automatic test_branch();
    go_to_fd8();
    FD_branch_taken = 1; FD_branch_target = 32'h40;
    sb.push_back(32'h40);
    #1;
    pop(e); n_chk++;
    if (nextPC !== e) begin n_fail++; $display("FAIL br_nextpc: got %h want %h", nextPC, e); end
    sb.push_back(32'h40);
    tick();
    FD_branch_taken = 0;
    pop(e); n_chk++;
    if (i_addr !== e || FD_bubble !== 1'b1) begin
      n_fail++; $display("FAIL br_redirect: got %h b %b want %h b 1", i_addr, FD_bubble, e);
    end
    sb.push_back(32'h40);
    tick();
    pop(e); n_chk++;
    if (FD_pc !== e || FD_bubble !== 1'b0) begin
      n_fail++; $display("FAIL br_fd_target: got %h b %b want %h b 0", FD_pc, FD_bubble, e);
    end
    n_chk++;
    if (XB_bubble !== 1'b1) begin
      n_fail++; $display("FAIL br_squash: got xb %h b %b want bubble 1", XB_pc, XB_bubble);
    end
  endtask

  task automatic test_misaligned();
    go_to_fd8();
    FD_branch_taken = 1; FD_branch_target = 32'h42;
    sb.push_back(32'h42);
    #1;
    pop(e); n_chk++;
    if (nextPC !== e) begin n_fail++; $display("FAIL mis_nextpc: got %h want %h", nextPC, e); end
    sb.push_back(32'h08);
    sb.push_back(32'h10);
    tick();
    FD_branch_taken = 0;
    pop(e); n_chk++;
    if (XB_pc !== e || XB_bubble !== 1'b0 || mis_flag !== 1'b1) begin
      n_fail++; $display("FAIL mis_xb: got %h b %b f %b want %h b 0 f 1", XB_pc, XB_bubble, mis_flag, e);
    end
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL mis_seq: got %h want %h", i_addr, e); end
    initiate_exception = 1; csr_mtvec = 32'h04;
    sb.push_back(32'h04);
    tick();
    initiate_exception = 0;
    pop(e); n_chk++;
    if (i_addr !== e || FD_bubble !== 1'b1 || XB_bubble !== 1'b1 || mis_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL trap: got %h fb %b xb %b f %b want %h 1 1 0", i_addr, FD_bubble, XB_bubble, mis_flag, e);
    end
  endtask

  task automatic test_trap_stall();
    go_to_fd8();
    stall = 1; initiate_exception = 1; csr_mtvec = 32'h100;
    sb.push_back(32'h100);
    tick();
    stall = 0; initiate_exception = 0;
    pop(e); n_chk++;
    if (i_addr !== e || FD_bubble !== 1'b1 || XB_bubble !== 1'b1) begin
      n_fail++; $display("FAIL trap_stall: got %h fb %b xb %b want %h 1 1", i_addr, FD_bubble, XB_bubble, e);
    end
  endtask

  task automatic test_mret();
    go_to_fd8();
    FD_mret = 1; csr_mepc = 32'h200;
    sb.push_back(32'h200);
    sb.push_back(32'h08);
    tick();
    FD_mret = 0;
    pop(e); n_chk++;
    if (i_addr !== e || FD_bubble !== 1'b1) begin
      n_fail++; $display("FAIL mret_redirect: got %h b %b want %h b 1", i_addr, FD_bubble, e);
    end
    pop(e); n_chk++;
    if (XB_pc !== e || XB_bubble !== 1'b0) begin
      n_fail++; $display("FAIL mret_xb: got %h b %b want %h b 0", XB_pc, XB_bubble, e);
    end
    go_to_fd8();
    FD_mret = 1; csr_mepc = 32'h300;
    FD_branch_taken = 1; FD_branch_target = 32'h40;
    sb.push_back(32'h300);
    tick();
    FD_mret = 0; FD_branch_taken = 0;
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL mret_wins: got %h want %h", i_addr, e); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(32'h20);
      sb.push_back(32'h1C);
      sb.push_back(32'h18);
      sb.push_back(32'h20);
      tick();
      pop(e); n_chk++;
      if (i_addr !== e) begin n_fail++; $display("FAIL stall_iaddr%0d: got %h want %h", i, i_addr, e); end
      pop(e); n_chk++;
      if (FD_pc !== e || FD_bubble !== 1'b0) begin
        n_fail++; $display("FAIL stall_fd%0d: got %h b %b want %h b 0", i, FD_pc, FD_bubble, e);
      end
      pop(e); n_chk++;
      if (XB_pc !== e || XB_bubble !== 1'b0 || mis_flag !== 1'b0) begin
        n_fail++; $display("FAIL stall_xb%0d: got %h b %b want %h b 0", i, XB_pc, XB_bubble, e);
      end
      pop(e); n_chk++;
      if (nextPC !== e) begin n_fail++; $display("FAIL stall_nextpc%0d: got %h want %h", i, nextPC, e); end
    end
    stall = 0;
    sb.push_back(32'h24);
    tick();
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL stall_resume: got %h want %h", i_addr, e); end
  endtask

  task automatic test_wrap();
    go_to_fd8();
    FD_branch_taken = 1; FD_branch_target = 32'hFFFF_FFFC;
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    tick();
    FD_branch_taken = 0;
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL wrap_target: got %h want %h", i_addr, e); end
    tick();
    pop(e); n_chk++;
    if (i_addr !== e) begin n_fail++; $display("FAIL wrap_iaddr: got %h want %h", i_addr, e); end
    pop(e); n_chk++;
    if (nextPC !== e) begin n_fail++; $display("FAIL wrap_nextpc: got %h want %h", nextPC, e); end
  endtask

  task automatic test_reset_midop();
    go_to_fd8();
    FD_branch_taken = 1; FD_branch_target = 32'h42;
    tick();
    FD_branch_taken = 0;
    reset = 1;
    sb.push_back(32'h0);
    tick();
    reset = 0;
    pop(e); n_chk++;
    if (i_addr !== e || FD_pc !== 32'h0 || XB_pc !== 32'h0 ||
        FD_bubble !== 1'b1 || XB_bubble !== 1'b1 || mis_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: got ia %h fd %h xb %h fb %b xbb %b f %b want all reset",
               i_addr, FD_pc, XB_pc, FD_bubble, XB_bubble, mis_flag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_branch();
    test_misaligned();
    test_trap_stall();
    test_mret();
    test_stall();
    test_wrap();
    test_reset_midop();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
